// File: rtl/in_debouncer.sv
// rtl/in_debouncer.sv - per-bit synchroniser, bounce filter and rise/fall event generator
`timescale 1ns/1ps
module in_debouncer #(
  parameter int WIDTH           = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 3000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] in_stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync;
  state_t                            state_q [WIDTH];
  state_t                            state_d [WIDTH];
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  stable_q, stable_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic                              changed_q, changed_d;

  // Plain shift chain: stage 0 takes the raw pin, the last stage feeds the filter.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (sync[i] != stable_q[i]) begin
            state_d[i] = ST_COUNTING;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_COUNTING: begin
          if (sync[i] == stable_q[i]) begin
            // Bounce back: discard all accumulated credit.
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i]  = ST_STABLE;
            cnt_d[i]    = '0;
            stable_d[i] = sync[i];
            rise_d[i]   = sync[i];
            fall_d[i]   = ~sync[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
      end
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign in_stable = stable_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_in_debouncer.sv
// tb/tb_in_debouncer.sv - scoreboard bench for in_debouncer against a run-length reference model
`timescale 1ns/1ps
module tb_in_debouncer;

  localparam int W = 5;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_r;
  logic [W-1:0] in_stable;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;

  int checks = 0;
  int errors = 0;

  in_debouncer #(
    .WIDTH(W),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in_r),
    .in_stable(in_stable),
    .rise(rise),
    .fall(fall),
    .changed(changed)
  );

  initial begin
    clk = 1'b0;
    forever #1.6665 clk = ~clk;
  end

  // Reference model: the filter sees `in` delayed by S edges and accepts a new
  // level once it has been seen on D+1 consecutive edges.
  logic [W-1:0] m_stable;
  int           m_run [W];
  logic [W-1:0] dq [$];
  logic [15:0]  exp_q [$];
  logic [W-1:0] m_s, m_r, m_f;

  always @(posedge clk) begin
    if (rst) begin
      m_stable = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      dq.delete();
      for (int i = 0; i < S; i++) dq.push_back('0);
      exp_q.push_back(16'h0);
    end else begin
      m_s = dq.pop_front();
      dq.push_back(in_r);
      m_r = '0;
      m_f = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s[i] != m_stable[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == D + 1) begin
          m_run[i] = 0;
          m_stable[i] = m_s[i];
          if (m_s[i]) m_r[i] = 1'b1;
          else m_f[i] = 1'b1;
        end
      end
      exp_q.push_back({m_stable, m_r, m_f, |(m_r | m_f)});
    end
  end

  logic [15:0] exp_v;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({in_stable, rise, fall, changed} !== exp_v) begin
        errors++;
        $display("FAIL scoreboard t=%0t: stable=%b rise=%b fall=%b changed=%b, expected stable=%b rise=%b fall=%b changed=%b",
                 $time, in_stable, rise, fall, changed,
                 exp_v[15:11], exp_v[10:6], exp_v[5:1], exp_v[0]);
      end
    end
  end

  // Edge index (0 = first edge after the stimulus change) of the first pulse matching the masks.
  task automatic wait_pulse(input logic [W-1:0] rm, input logic [W-1:0] fm,
                            input int exp_k, input string nm);
    int k;
    k = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (k < 0 && changed && ((rise & rm) == rm) && ((fall & fm) == fm)) k = e;
    end
    checks++;
    if (k != exp_k) begin
      errors++;
      $display("FAIL %s: pulse seen at edge %0d, expected edge %0d", nm, k, exp_k);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    in_r = 5'b11111;
    hold(4);
    checks++;
    if ({in_stable, rise, fall, changed} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got %h, expected 0000", {in_stable, rise, fall, changed});
    end

    // Power-up with all inputs high
    rst = 1'b0;
    wait_pulse(5'b11111, 5'b00000, S + D, "powerup_rise");
    hold(3);

    // Clean fall on bit 2
    in_r = 5'b11011;
    wait_pulse(5'b00000, 5'b00100, S + D, "clean_fall");
    hold(1);

    // Return to all-low, then a 3-cycle glitch on bit 0
    in_r = 5'b00000;
    hold(15);
    in_r[0] = 1'b1;
    hold(3);
    in_r[0] = 1'b0;
    hold(12);

    // Bounce on bit 1, then hold high
    for (int c = 0; c < 10; c++) begin
      in_r[1] = c[1];
      hold(1);
    end
    in_r[1] = 1'b1;
    wait_pulse(5'b00010, 5'b00000, S + D, "bounce_rise");
    hold(1);

    // Reset in the middle of a count on bit 3
    in_r[3] = 1'b1;
    hold(3);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    wait_pulse(5'b01000, 5'b00000, S + D, "reset_mid_rise");
    hold(1);

    // Simultaneous rise and fall on different bits
    in_r = 5'b10000;
    hold(15);
    in_r = 5'b00001;
    wait_pulse(5'b00001, 5'b10000, S + D, "simul_rise_fall");
    hold(1);
    checks++;
    if (in_stable !== 5'b00001) begin
      errors++;
      $display("FAIL simul_final: in_stable=%b, expected 00001", in_stable);
    end

    // Randomised bouncing with calm and noisy phases plus rare resets
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = ((c / 200) % 2 == 0) ? 3 : 40;
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, p - 1) == 0) in_r[i] = ~in_r[i];
      end
      rst = ($urandom_range(0, 599) == 0);
      hold(1);
    end
    rst = 1'b0;
    hold(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
